dynamic_branch_predictor: RTL

DYNAMIC_BRANCH_PREDICTOR -- requirements
Module: dynamic_branch_predictor

---
 rtl/dynamic_branch_predictor.sv | 88 ++++++++
 1 files changed

// File: rtl/dynamic_branch_predictor.sv
// Direct-mapped branch predictor: 2-bit saturating BHT plus tagged BTB.
// The lookup is combinational, the decode-stage update is registered, and mispredictions are counted.
module dynamic_branch_predictor #(
    parameter int IDX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [15:0] PC_curr,
    input  logic [15:0] IF_ID_PC_curr,
    input  logic        wen_BHT,
    input  logic        wen_BTB,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    input  logic        update_PC,
    output logic        predicted_taken,
    output logic [15:0] predicted_target,
    output logic [15:0] mispredict_count
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam int TAG_W = 15 - IDX_BITS;

    logic [DEPTH-1:0][1:0]       bht_q, bht_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [DEPTH-1:0][15:0]      tgt_q, tgt_d;
    logic [15:0]                 cnt_q, cnt_d;

    logic [IDX_BITS-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]    rd_tag, wr_tag;
    logic                hit;

    assign rd_idx = PC_curr[IDX_BITS:1];
    assign rd_tag = PC_curr[15:IDX_BITS+1];
    assign wr_idx = IF_ID_PC_curr[IDX_BITS:1];
    assign wr_tag = IF_ID_PC_curr[15:IDX_BITS+1];

    // Reads see registered state only, so a same-cycle update shows up next cycle.
    assign hit              = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign predicted_taken  = hit && bht_q[rd_idx][1];
    assign predicted_target = predicted_taken ? tgt_q[rd_idx] : PC_curr + 16'd2;
    assign mispredict_count = cnt_q;

    // enable only tells fetch the prediction was consumed; bit 0 of each PC is alignment.
    logic unused_ok;
    assign unused_ok = &{1'b0, enable, PC_curr[0], IF_ID_PC_curr[0]};

    always_comb begin
        bht_d   = bht_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (wen_BHT) begin
            if (actual_taken && bht_q[wr_idx] != 2'b11)
                bht_d[wr_idx] = bht_q[wr_idx] + 2'b01;
            else if (!actual_taken && bht_q[wr_idx] != 2'b00)
                bht_d[wr_idx] = bht_q[wr_idx] - 2'b01;
        end
        if (wen_BTB) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            tgt_d[wr_idx]   = actual_target;
        end
        if (update_PC && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_q[i] <= 2'b01;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            bht_q   <= bht_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
